// File: rtl/lsu_mem_master.sv
// Load/store unit memory master: one request at a time, sub-word stores done
// as read-modify-write on a single-port word memory.
module lsu_mem_master (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        we_q, we_d;
    logic        req_ready_q, req_ready_d;
    logic        mem_re_q, mem_re_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    function automatic logic is_err(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] off,
                                             input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            2'b00:   return {{24{~uns & sh[7]}}, sh[7:0]};
            2'b01:   return {{16{~uns & sh[15]}}, sh[15:0]};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [31:0] wdata,
                                               input logic [1:0] off, input logic [1:0] size);
        logic [31:0] mask;
        mask = (size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
        mask = mask << {off, 3'b000};
        return (word & ~mask) | ((wdata << {off, 3'b000}) & mask);
    endfunction

    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        uns_d       = uns_q;
        we_d        = we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    off_d       = req_addr[1:0];
                    wdata_d     = req_wdata;
                    size_d      = req_size;
                    uns_d       = req_unsigned;
                    we_d        = req_we;
                    mem_addr_d  = {req_addr[31:2], 2'b00};
                    mem_wdata_d = req_wdata;
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = 1'b0;
                    if (is_err(req_size, req_addr[1:0])) begin
                        state_d   = RESP;
                        rsp_err_d = 1'b1;
                    end else if (!req_we || req_size != 2'b10) begin
                        state_d = RD;
                    end else begin
                        state_d = WR;
                    end
                end
            end
            // mem_rdata is consumed directly at the end of RD: into the merged
            // store word for read-modify-write, or into the extended load result.
            RD: begin
                if (we_q) begin
                    state_d     = WR;
                    mem_wdata_d = merge_lane(mem_rdata, wdata_q, off_q, size_q);
                end else begin
                    state_d     = RESP;
                    rsp_rdata_d = load_ext(mem_rdata, off_q, size_q, uns_q);
                end
            end
            WR:      state_d = RESP;
            default: begin
                if (rsp_ready) state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        req_ready_d = (state_d == IDLE);
        mem_re_d    = (state_d == RD);
        mem_we_d    = (state_d == WR);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            off_q       <= 2'b00;
            wdata_q     <= 32'h0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            we_q        <= 1'b0;
            req_ready_q <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            we_q        <= we_d;
            req_ready_q <= req_ready_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Gating with rst keeps the memory from writing at the reset edge itself.
    assign mem_re    = mem_re_q & rst;
    assign mem_we    = mem_we_q & rst;
    assign req_ready = req_ready_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master: directed requests push expected
// responses, a negedge monitor pops and compares them on each handshake.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_re;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    always #5 clk = ~clk;

    lsu_mem_master dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    // Word memory model with a bench-side preload port
    logic [31:0] mem [0:255];
    logic        pre_en;
    logic [7:0]  pre_idx;
    logic [31:0] pre_data;
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
        else if (pre_en) mem[pre_idx] <= pre_data;
    end

    int cyc = 0, re_cnt = 0, we_cnt = 0, both_cnt = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_re) re_cnt <= re_cnt + 1;
        if (mem_we) we_cnt <= we_cnt + 1;
        if (mem_re && mem_we) both_cnt <= both_cnt + 1;
    end

    int checks = 0, passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    logic vld_prev = 1'b0;
    int   first_cyc = 0;

    always @(negedge clk) begin
        if (rsp_valid && !vld_prev) first_cyc = cyc;
        vld_prev = rsp_valid;
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'h0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, mon_e.rdata);
                chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
                chk("latency", 32'(first_cyc - mon_e.acc), 32'(mon_e.lat));
            end
        end
    end

    task automatic preload(input logic [7:0] idx, input logic [31:0] data);
        pre_idx = idx; pre_data = data; pre_en = 1'b1;
        @(posedge clk); #1 pre_en = 1'b0;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns, input logic push,
                         input logic [31:0] er, input logic ee, input int lat);
        int   n;
        exp_t x;
        req_we = we; req_addr = addr; req_wdata = wdata; req_size = size;
        req_unsigned = uns; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'(req_ready), 32'h1);
            req_valid = 1'b0;
        end else begin
            if (push) begin
                x.rdata = er; x.err = ee; x.lat = lat; x.acc = cyc;
                exp_q.push_back(x);
            end
            @(posedge clk); #1 req_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("rsp_timeout", 32'(exp_q.size()), 32'h0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [1:0] size, input logic uns, input logic [31:0] er,
                      input logic ee, input int lat, input int exp_re, input int exp_we);
        int r0, w0;
        r0 = re_cnt; w0 = we_cnt;
        issue(we, addr, wdata, size, uns, 1'b1, er, ee, lat);
        drain();
        chk("re_cycles", 32'(re_cnt - r0), 32'(exp_re));
        chk("we_cycles", 32'(we_cnt - w0), 32'(exp_we));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b0; rsp_ready = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_size = 2'b00; req_unsigned = 1'b0;
        pre_en = 1'b0; pre_idx = 8'h0; pre_data = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_mem_re", 32'(mem_re), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("ready_after_rst", 32'(req_ready), 32'h1);

        // Byte store RMW, then word store
        preload(8'd64, 32'h1122_3344);
        op(1'b1, 32'h101, 32'h0000_00AA, 2'b00, 1'b0, 32'h0, 1'b0, 3, 1, 1);
        chk("mem_byte_store", mem[64], 32'h1122_AA44);
        op(1'b1, 32'h100, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0, 1'b0, 2, 0, 1);
        chk("mem_word_store", mem[64], 32'hDEAD_BEEF);

        // Loads with extension
        preload(8'd64, 32'h80FF_0000);
        op(1'b0, 32'h103, 32'h0, 2'b00, 1'b0, 32'hFFFF_FF80, 1'b0, 2, 1, 0);
        op(1'b0, 32'h103, 32'h0, 2'b00, 1'b1, 32'h0000_0080, 1'b0, 2, 1, 0);
        op(1'b0, 32'h102, 32'h0, 2'b01, 1'b0, 32'hFFFF_80FF, 1'b0, 2, 1, 0);
        op(1'b0, 32'h102, 32'h0, 2'b01, 1'b1, 32'h0000_80FF, 1'b0, 2, 1, 0);
        op(1'b0, 32'h102, 32'h0, 2'b00, 1'b1, 32'h0000_00FF, 1'b0, 2, 1, 0);
        op(1'b0, 32'h100, 32'h0, 2'b10, 1'b1, 32'h80FF_0000, 1'b0, 2, 1, 0);

        // Half store RMW into the upper lane
        op(1'b1, 32'h102, 32'hABCD_1234, 2'b01, 1'b0, 32'h0, 1'b0, 3, 1, 1);
        chk("mem_half_store", mem[64], 32'h1234_0000);

        // Error cases: no memory activity, latency 1
        op(1'b0, 32'h103, 32'h0, 2'b01, 1'b0, 32'h0, 1'b1, 1, 0, 0);
        op(1'b0, 32'h102, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1, 1, 0, 0);
        op(1'b0, 32'h100, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1, 1, 0, 0);
        op(1'b1, 32'h101, 32'hFFFF, 2'b01, 1'b0, 32'h0, 1'b1, 1, 0, 0);
        chk("mem_after_err", mem[64], 32'h1234_0000);

        // Consumer back-pressure
        rsp_ready = 1'b0;
        issue(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 1'b1, 32'h1234_0000, 1'b0, 2);
        n = 0;
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(rsp_valid), 32'h1);
            chk("hold_rdata", rsp_rdata, 32'h1234_0000);
            chk("hold_req_ready", 32'(req_ready), 32'h0);
            @(negedge clk);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("idle_after_hold", 32'(req_ready), 32'h1);
        chk("valid_after_hold", 32'(rsp_valid), 32'h0);
        chk("hold_drained", 32'(exp_q.size()), 32'h0);

        // Reset during the write cycle of a sub-word store
        preload(8'd129, 32'hCAFE_F00D);
        n = we_cnt;
        issue(1'b1, 32'h205, 32'h55, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 0);
        @(negedge clk);
        chk("wr_phase_we", 32'(mem_we), 32'h1);
        rst = 1'b0;
        #1;
        chk("we_gated_by_rst", 32'(mem_we), 32'h0);
        repeat (2) @(negedge clk);
        chk("rst_abort_valid", 32'(rsp_valid), 32'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("ready_after_abort", 32'(req_ready), 32'h1);
        chk("abort_valid", 32'(rsp_valid), 32'h0);
        chk("mem_after_abort", mem[129], 32'hCAFE_F00D);
        chk("abort_we_cycles", 32'(we_cnt - n), 32'h0);
        op(1'b0, 32'h204, 32'h0, 2'b10, 1'b0, 32'hCAFE_F00D, 1'b0, 2, 1, 0);

        chk("re_we_exclusive", 32'(both_cnt), 32'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
